font_rom_arbiter: RTL and testbench
===================================

FONT_ROM_ARBITER -- requirements
Module: font_rom_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of glyph requesters (time, date, chronometer digit layers).
REQ-002 Parameter CODE_W, default 4, BCD character code width.
REQ-003 Parameter ROW_W, default 4, glyph row index width.
REQ-004 Parameter DATA_W, default 8, glyph row bitmap width.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  arbitration enable (video/state-machine ready); low blocks new grants.
REQ-008 req  input  N_REQ  per-requester lookup request, held until granted.
REQ-009 code_i  input  N_REQ*CODE_W  flattened character codes, requester k at bits [k*CODE_W +: CODE_W].
REQ-010 row_i  input  N_REQ*ROW_W  flattened glyph row indices, same packing.
REQ-011 gnt  output  N_REQ  one-hot grant, combinational, same cycle as winning req.
REQ-012 rom_code  output  CODE_W  registered font ROM character select.
REQ-013 rom_row  output  ROW_W  registered font ROM row select.
REQ-014 rom_data  input  DATA_W  font ROM row bitmap, valid one cycle after rom_code/rom_row.
REQ-015 rsp_valid  output  N_REQ  one-hot response strobe, one cycle wide.
REQ-016 rsp_data  output  DATA_W  glyph row bitmap for the strobed requester.

Function
REQ-017 At most one gnt bit high per cycle; gnt all-zero when en=0 or req=0.
REQ-018 Winner: first requester with req=1 searching from pointer ptr upward, modulo N_REQ.
REQ-019 After a grant to k, ptr becomes (k+1) mod N_REQ on the next edge; ptr unchanged with no grant.
REQ-020 Grant in cycle t: rom_code/rom_row load winner's code_i/row_i at edge t+1; tag stage 1 loads k.
REQ-021 Tag and blank flag advance to stage 2 at edge t+2; rsp_valid[k]=1 during cycle t+2 only; latency exactly 2 cycles grant-to-response.
REQ-022 Pipeline fully pipelined: one grant per cycle sustained, responses in grant order.
REQ-023 Code > 9 (non-BCD) SHALL return rsp_data = 0 (blank glyph); ROM still addressed, its data masked.
REQ-024 rsp_data = 0 whenever rsp_valid = 0.
REQ-025 en deasserted mid-stream: no new grants from that cycle; in-flight lookups still complete and respond.
REQ-026 Requester dropping req before grant: no grant, no response, ptr unaffected.
REQ-027 rom_code/rom_row hold last value when no grant.
REQ-028 Bounded wait: any held req granted within N_REQ cycles while en=1.

Reset
REQ-029 reset low: ptr=0, rom_code=0, rom_row=0, pipeline tags invalid, rsp_valid=0, rsp_data=0, immediately (asynchronous).
REQ-030 Reset mid-operation discards in-flight lookups; no response emitted for them after release.
REQ-031 First grant possible in the first cycle after reset release with en=1.

Structure
REQ-032 Shared package font_pkg holds N_REQ, CODE_W, ROW_W, DATA_W defaults, BCD_MAX=9, BLANK_ROW=0.
REQ-033 Round-robin selection in sub-module rr_arbiter (req, ptr in; one-hot gnt, winner index out); pipeline and masking in top.

Verification
REQ-034 Reset release, en=1, req=3'b001, code0=5, row0=3 -> gnt=001 same cycle, rom_code=5/rom_row=3 at +1, rsp_valid=001 with rsp_data=rom_data at +2.
REQ-035 req=3'b111 held 6 cycles, ptr=0 -> gnt sequence 001,010,100,001,010,100; rsp_valid same sequence delayed 2 cycles.
REQ-036 code1=4'hB, req=010 -> rsp_valid=010 at +2 with rsp_data=8'h00 despite rom_data=8'hFF.
REQ-037 req=111, en dropped after 2 grants -> no further gnt; exactly 2 responses delivered.
REQ-038 reset asserted in cycle after a grant -> rsp_valid stays 0, ptr=0, no response after release.
REQ-039 req=101 continuous with ptr=1 -> grants alternate 100,001; requester 1 never strobed.

Source files
------------

// File: rtl/font_pkg.sv
// Shared defaults and glyph constants for the font ROM arbiter slice.
package font_pkg;
  localparam int unsigned N_REQ     = 3;
  localparam int unsigned CODE_W    = 4;
  localparam int unsigned ROW_W     = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BCD_MAX   = 9;
  localparam int unsigned BLANK_ROW = 0;
endpackage

// File: rtl/font_rom_arbiter_rr_arbiter.sv
// Round-robin selector: first active request at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);
  import font_pkg::*;

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[IDX_W-1:0]]  = 1'b1;
        idx                   = cand[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one font ROM among several glyph requesters; two-cycle lookup pipeline
// with non-BCD codes answered by a blank row.
module font_rom_arbiter #(
  parameter int unsigned N_REQ  = font_pkg::N_REQ,
  parameter int unsigned CODE_W = font_pkg::CODE_W,
  parameter int unsigned ROW_W  = font_pkg::ROW_W,
  parameter int unsigned DATA_W = font_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*CODE_W-1:0]   code_i,
  input  logic [N_REQ*ROW_W-1:0]    row_i,
  output logic [N_REQ-1:0]          gnt,
  output logic [CODE_W-1:0]         rom_code,
  output logic [ROW_W-1:0]          rom_row,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);
  import font_pkg::*;

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  req_en;
  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              any_gnt;
  logic [CODE_W-1:0] win_code;
  logic [ROW_W-1:0]  win_row;

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CODE_W-1:0] rom_code_q, rom_code_d;
  logic [ROW_W-1:0]  rom_row_q, rom_row_d;
  logic              s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [IDX_W-1:0]  s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic              s1_blank_q, s1_blank_d, s2_blank_q, s2_blank_d;

  assign req_en = en ? req : '0;

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req (req_en),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign gnt      = arb_gnt;
  assign any_gnt  = |arb_gnt;
  assign win_code = code_i[arb_idx*CODE_W +: CODE_W];
  assign win_row  = row_i[arb_idx*ROW_W +: ROW_W];

  always_comb begin
    ptr_d      = ptr_q;
    rom_code_d = rom_code_q;
    rom_row_d  = rom_row_q;
    if (any_gnt) begin
      ptr_d      = (arb_idx == IDX_W'(N_REQ-1)) ? '0 : arb_idx + IDX_W'(1);
      rom_code_d = win_code;
      rom_row_d  = win_row;
    end
    // Blank decision travels with the tag; the ROM is still addressed normally.
    s1_vld_d   = any_gnt;
    s1_tag_d   = arb_idx;
    s1_blank_d = (win_code > CODE_W'(BCD_MAX));
    s2_vld_d   = s1_vld_q;
    s2_tag_d   = s1_tag_q;
    s2_blank_d = s1_blank_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      rom_code_q <= '0;
      rom_row_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_tag_q   <= '0;
      s1_blank_q <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_tag_q   <= '0;
      s2_blank_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rom_code_q <= rom_code_d;
      rom_row_q  <= rom_row_d;
      s1_vld_q   <= s1_vld_d;
      s1_tag_q   <= s1_tag_d;
      s1_blank_q <= s1_blank_d;
      s2_vld_q   <= s2_vld_d;
      s2_tag_q   <= s2_tag_d;
      s2_blank_q <= s2_blank_d;
    end
  end

  assign rom_code = rom_code_q;
  assign rom_row  = rom_row_q;

  always_comb begin
    rsp_valid = '0;
    rsp_data  = DATA_W'(BLANK_ROW);
    if (s2_vld_q) begin
      rsp_valid[s2_tag_q] = 1'b1;
      if (!s2_blank_q) rsp_data = rom_data;
    end
  end
endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter with a registered font ROM model.
module tb_font_rom_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  req = '0;
  logic [11:0] code_i = '0;
  logic [11:0] row_i = '0;
  logic [2:0]  gnt;
  logic [3:0]  rom_code;
  logic [3:0]  rom_row;
  logic [7:0]  rom_data;
  logic [2:0]  rsp_valid;
  logic [7:0]  rsp_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  font_rom_arbiter #(.N_REQ(3), .CODE_W(4), .ROW_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .code_i    (code_i),
    .row_i     (row_i),
    .gnt       (gnt),
    .rom_code  (rom_code),
    .rom_row   (rom_row),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  // ROM: row bitmap = {code,row}, except code B returns all ones.
  always @(posedge clk) rom_data <= (rom_code == 4'hB) ? 8'hFF : {rom_code, rom_row};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_code(input int k, input logic [3:0] c, input logic [3:0] r);
    code_i[k*4 +: 4] = c;
    row_i[k*4 +: 4]  = r;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en    = 1'b0;
    req   = '0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ge, re;
    logic [7:0] de;
    int unsigned nresp;

    // Reset values
    tick(); tick();
    sample();
    check("rst_gnt", gnt, 3'b000);
    check("rst_rom_code", rom_code, 4'h0);
    check("rst_rom_row", rom_row, 4'h0);
    check("rst_rsp_valid", rsp_valid, 3'b000);
    check("rst_rsp_data", rsp_data, 8'h00);
    tick();

    // Single lookup immediately after reset release
    reset = 1'b1; en = 1'b1; req = 3'b001; set_code(0, 4'd5, 4'd3);
    sample(); check("t1_gnt", gnt, 3'b001);
    tick(); req = '0;
    sample();
    check("t1_rom_code", rom_code, 4'd5);
    check("t1_rom_row", rom_row, 4'd3);
    check("t1_rsp_early", rsp_valid, 3'b000);
    tick();
    sample();
    check("t1_rsp_valid", rsp_valid, 3'b001);
    check("t1_rsp_data", rsp_data, 8'h53);
    tick();
    sample();
    check("t1_rsp_off", rsp_valid, 3'b000);
    check("t1_data_off", rsp_data, 8'h00);
    check("t1_rom_hold", rom_code, 4'd5);
    tick();

    // Full round robin from ptr=0
    do_reset();
    set_code(0, 4'd1, 4'd0); set_code(1, 4'd2, 4'd1); set_code(2, 4'd3, 4'd2);
    en = 1'b1; req = 3'b111;
    for (int c = 0; c < 9; c++) begin
      if (c == 6) req = '0;
      sample();
      ge = (c < 6) ? (3'b001 << (c % 3)) : 3'b000;
      re = (c >= 2 && c < 8) ? (3'b001 << ((c - 2) % 3)) : 3'b000;
      case (re)
        3'b001:  de = 8'h10;
        3'b010:  de = 8'h21;
        3'b100:  de = 8'h32;
        default: de = 8'h00;
      endcase
      check($sformatf("t2_gnt_%0d", c), gnt, ge);
      check($sformatf("t2_rsp_%0d", c), rsp_valid, re);
      check($sformatf("t2_dat_%0d", c), rsp_data, de);
      tick();
    end

    // Non-BCD code is blanked despite ROM returning FF
    set_code(1, 4'hB, 4'd7); req = 3'b010;
    sample(); check("t3_gnt", gnt, 3'b010);
    tick(); req = '0;
    sample(); check("t3_rom_code", rom_code, 4'hB);
    tick();
    sample();
    check("t3_rsp_valid", rsp_valid, 3'b010);
    check("t3_rsp_data", rsp_data, 8'h00);
    tick();
    set_code(1, 4'd2, 4'd1);

    // en dropped after two grants (ptr=2)
    nresp = 0;
    req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) en = 1'b0;
      sample();
      ge = (c == 0) ? 3'b100 : (c == 1) ? 3'b001 : 3'b000;
      re = (c == 2) ? 3'b100 : (c == 3) ? 3'b001 : 3'b000;
      de = (c == 2) ? 8'h32 : (c == 3) ? 8'h10 : 8'h00;
      check($sformatf("t4_gnt_%0d", c), gnt, ge);
      check($sformatf("t4_rsp_%0d", c), rsp_valid, re);
      check($sformatf("t4_dat_%0d", c), rsp_data, de);
      if (rsp_valid != 3'b000) nresp++;
      tick();
    end
    check("t4_nresp", nresp, 2);
    req = '0; en = 1'b1;

    // Reset right after a grant discards the lookup (ptr=1 here)
    req = 3'b001;
    sample(); check("t5_gnt", gnt, 3'b001);
    tick();
    reset = 1'b0; req = '0;
    #1;
    check("t5_async_rsp", rsp_valid, 3'b000);
    check("t5_async_code", rom_code, 4'h0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      check($sformatf("t5_norsp_%0d", c), rsp_valid, 3'b000);
      tick();
    end
    req = 3'b111;
    sample(); check("t5_ptr0", gnt, 3'b001);
    tick(); req = '0;
    tick(); tick();

    // req=101 with ptr=1: alternate 100,001
    req = 3'b101;
    for (int c = 0; c < 7; c++) begin
      if (c == 4) req = '0;
      sample();
      ge = (c < 4) ? ((c % 2 == 0) ? 3'b100 : 3'b001) : 3'b000;
      re = (c >= 2 && c < 6) ? (((c - 2) % 2 == 0) ? 3'b100 : 3'b001) : 3'b000;
      de = (re == 3'b100) ? 8'h32 : (re == 3'b001) ? 8'h10 : 8'h00;
      check($sformatf("t6_gnt_%0d", c), gnt, ge);
      check($sformatf("t6_rsp_%0d", c), rsp_valid, re);
      check($sformatf("t6_dat_%0d", c), rsp_data, de);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
